// File: rtl/tcm_lsu.sv
// tcm_lsu: single-outstanding load/store initiator for TCM port B.
// Optional grant timeout enabled by defining TCM_LSU_TIMEOUT_EN.
module tcm_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] address_b,
  output logic        request_b,
  output logic        write_enable_b,
  output logic [3:0]  write_byte_enable_b,
  output logic [31:0] write_data_b,
  input  logic [31:0] read_data_b,
  input  logic        grant_b,
  input  logic        valid_b
);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, RESP = 2'd3;
  logic [1:0]  state;
  logic [1:0]  off;
  logic [1:0]  size;
  logic        uns;
  logic        err;
  logic        bad;
  logic        expired;
  logic [3:0]  be_n;
  logic [31:0] wd_n;
  logic [7:0]  b_lane;
  logic [15:0] h_lane;
  logic [31:0] ext;
  assign bad = req_size == 2'd3 || (req_size == 2'd1 && req_addr[0]) ||
               (req_size == 2'd2 && req_addr[1:0] != 2'd0);
  always_comb begin
    be_n   = req_size == 2'd0 ? 4'b0001 << req_addr[1:0] :
             req_size == 2'd1 ? 4'b0011 << req_addr[1:0] : 4'hF;
    wd_n   = req_size == 2'd0 ? {4{req_wdata[7:0]}} :
             req_size == 2'd1 ? {2{req_wdata[15:0]}} : req_wdata;
    b_lane = 8'(read_data_b >> {off, 3'b000});
    h_lane = 16'(read_data_b >> {off[1], 4'b0000});
    ext    = size == 2'd0 ? {{24{~uns & b_lane[7]}}, b_lane} :
             size == 2'd1 ? {{16{~uns & h_lane[15]}}, h_lane} : read_data_b;
  end
`ifdef TCM_LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  // Counter is held at zero outside REQ, so every REQ entry starts fresh.
  assign expired = state == REQ && !grant_b && cnt == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge aclk) cnt <= (areset || state != REQ) ? '0 : grant_b ? cnt : cnt + 1'b1;
`else
  assign expired = 1'b0;
`endif
  assign req_ready = state == IDLE && !areset;
  assign request_b = state == REQ;
  assign rsp_valid = state == RESP;
  assign rsp_err   = state == RESP && err;
  always_ff @(posedge aclk) begin
    if (areset) begin
      state               <= IDLE;
      address_b           <= '0;
      write_enable_b      <= 1'b0;
      write_byte_enable_b <= '0;
      write_data_b        <= '0;
      rsp_rdata           <= '0;
      err                 <= 1'b0;
      off                 <= '0;
      size                <= '0;
      uns                 <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          state               <= bad ? RESP : REQ;
          address_b           <= {req_addr[31:2], 2'b00};
          write_enable_b      <= req_we && !bad;
          write_byte_enable_b <= (req_we && !bad) ? be_n : 4'h0;
          write_data_b        <= req_we ? wd_n : 32'h0;
          rsp_rdata           <= '0;
          err                 <= bad;
          off                 <= req_addr[1:0];
          size                <= req_size;
          uns                 <= req_unsigned;
        end
        REQ: if (grant_b) state <= WAIT;
             else if (expired) begin
               state <= RESP;
               err   <= 1'b1;
             end
        WAIT: if (valid_b) begin
          state <= RESP;
          if (!write_enable_b) rsp_rdata <= ext;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tcm_lsu.sv
// tb_tcm_lsu: directed bench for tcm_lsu with a lane-level reference model.
module tb_tcm_lsu;
  localparam int TO = 16;
  logic        aclk = 1'b0, areset = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_addr = '0, req_wdata = '0, read_data_b = '0;
  logic        grant_b = 1'b0, valid_b = 1'b0;
  logic        req_ready, rsp_valid, rsp_err, request_b, write_enable_b;
  logic [31:0] rsp_rdata, address_b, write_data_b;
  logic [3:0]  write_byte_enable_b;
  int checks = 0, errors = 0;
  logic [31:0] e_addr, e_wd, e_rdata, l_addr, l_wd, l_rdata;
  logic [3:0]  e_be, l_be;
  logic        e_we, e_err, l_we, l_err;

  always #5 aclk = ~aclk;

  tcm_lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .aclk(aclk), .areset(areset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .address_b(address_b), .request_b(request_b), .write_enable_b(write_enable_b),
    .write_byte_enable_b(write_byte_enable_b), .write_data_b(write_data_b),
    .read_data_b(read_data_b), .grant_b(grant_b), .valid_b(valid_b)
  );

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", n, act, exp);
    end
  endtask

  // Reference: lanes touched are [off, off+n); store byte k takes source byte k mod n.
  task automatic model(input logic [31:0] a, input bit we, input logic [1:0] sz, input bit u,
                       input logic [31:0] wd, input logic [31:0] mem, input bit to);
    int n, off;
    longint v;
    n      = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
    off    = int'(a % 4);
    e_err  = to || sz == 2'd3 || (off % n) != 0;
    e_addr = a & ~32'h3;
    e_we   = we;
    e_be   = '0;
    for (int k = 0; k < 4; k++) begin
      if (we && k >= off && k < off + n) e_be[k] = 1'b1;
      e_wd[8*k +: 8] = 8'(wd >> (8 * (k % n)));
    end
    v = (longint'(mem) >> (8 * off)) & ((64'd1 << (8 * n)) - 1);
    if (!u && n < 4 && v[8*n-1]) v = v - (64'd1 << (8 * n));
    e_rdata = (we || e_err) ? 32'h0 : 32'(v);
  endtask

  always @(negedge aclk) if (!areset) begin
    if (request_b) begin
      chk("address_b", address_b, e_addr);
      chk("write_enable_b", 32'(write_enable_b), 32'(e_we));
      chk("byte_enable", 32'(write_byte_enable_b), 32'(e_be));
      if (e_we) chk("write_data_b", write_data_b, e_wd);
      l_addr = address_b; l_be = write_byte_enable_b; l_wd = write_data_b; l_we = write_enable_b;
    end
    if (rsp_valid) begin
      chk("rsp_rdata", rsp_rdata, e_rdata);
      chk("rsp_err", 32'(rsp_err), 32'(e_err));
      l_rdata = rsp_rdata; l_err = rsp_err;
    end
    if (rsp_valid || request_b) chk("ready_busy", 32'(req_ready), 32'h0);
  end

  task automatic op(input logic [31:0] a, input bit we, input logic [1:0] sz, input bit u,
                    input logic [31:0] wd, input logic [31:0] mem, input int gd, input bit to);
    int cyc, nreq, lat;
    bit granted, done;
    model(a, we, sz, u, wd, mem, to);
    @(negedge aclk);
    chk("ready_idle", 32'(req_ready), 32'h1);
    req_valid = 1'b1; req_addr = a; req_we = we; req_size = sz; req_unsigned = u; req_wdata = wd;
    @(posedge aclk); #1;
    req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = $urandom; req_size = 2'd0;
    cyc = 1; nreq = 0; granted = 1'b0; done = 1'b0; lat = 0;
    while (!done && cyc < 200) begin
      valid_b = granted;
      granted = 1'b0;
      read_data_b = valid_b ? mem : $urandom;
      if (request_b) begin
        nreq++;
        grant_b = nreq > gd && !to;
        granted = grant_b;
      end else grant_b = 1'b0;
      @(negedge aclk);
      if (rsp_valid) begin done = 1'b1; lat = cyc; end
      @(posedge aclk); #1;
      cyc++;
    end
    grant_b = 1'b0; valid_b = 1'b0;
    chk("latency", 32'(lat), 32'(to ? TO + 1 : e_err ? 1 : 3 + gd));
    chk("request_cycles", 32'(nreq), 32'(to ? TO : e_err ? 0 : gd + 1));
  endtask

  task automatic reset_in_wait();
    model(32'h200, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge aclk);
    req_valid = 1'b1; req_addr = 32'h200; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    @(posedge aclk); #1;
    req_valid = 1'b0;
    chk("rst_request", 32'(request_b), 32'h1);
    grant_b = request_b;
    @(posedge aclk); #1;
    grant_b = 1'b0; areset = 1'b1;
    @(negedge aclk);
    chk("rst_ready_low", 32'(req_ready), 32'h0);
    @(posedge aclk); #1;
    areset = 1'b0; valid_b = 1'b1; read_data_b = 32'h1234_5678;
    @(negedge aclk);
    chk("rst_request_b", 32'(request_b), 32'h0);
    chk("rst_we", 32'(write_enable_b), 32'h0);
    chk("rst_be", 32'(write_byte_enable_b), 32'h0);
    chk("rst_addr", address_b, 32'h0);
    chk("rst_wdata", write_data_b, 32'h0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_err", 32'(rsp_err), 32'h0);
    chk("rst_ready", 32'(req_ready), 32'h1);
    @(posedge aclk); #1;
    valid_b = 1'b0;
    repeat (3) begin
      @(negedge aclk);
      chk("rst_no_rsp", 32'(rsp_valid), 32'h0);
    end
  endtask

  initial begin
    model(32'h103, 1'b0, 2'd0, 1'b0, 32'h0, 32'h8011_2233, 1'b0);
    chk("model_sbyte", e_rdata, 32'hFFFF_FF80);
    model(32'h22, 1'b1, 2'd1, 1'b0, 32'h0000_ABCD, 32'h0, 1'b0);
    chk("model_half_be", 32'(e_be), 32'hC);
    chk("model_half_wd", e_wd, 32'hABCD_ABCD);
    @(posedge aclk);
    @(negedge aclk);
    chk("reset_ready", 32'(req_ready), 32'h0);
    chk("reset_request", 32'(request_b), 32'h0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset_be", 32'(write_byte_enable_b), 32'h0);
    chk("reset_addr", address_b, 32'h0);
    @(posedge aclk); #1;
    areset = 1'b0;
    @(negedge aclk);
    chk("ready_after_reset", 32'(req_ready), 32'h1);

    op(32'h100, 1'b0, 2'd2, 1'b0, 32'h0, 32'hDEAD_BEEF, 0, 1'b0);
    chk("lit_word_rdata", l_rdata, 32'hDEAD_BEEF);
    chk("lit_word_err", 32'(l_err), 32'h0);
    op(32'h103, 1'b0, 2'd0, 1'b0, 32'h0, 32'h8011_2233, 0, 1'b0);
    chk("lit_sbyte", l_rdata, 32'hFFFF_FF80);
    chk("lit_load_be", 32'(l_be), 32'h0);
    op(32'h103, 1'b0, 2'd0, 1'b1, 32'h0, 32'h8011_2233, 0, 1'b0);
    chk("lit_ubyte", l_rdata, 32'h0000_0080);
    op(32'h22, 1'b1, 2'd1, 1'b0, 32'h0000_ABCD, 32'h5555_5555, 0, 1'b0);
    chk("lit_hst_addr", l_addr, 32'h20);
    chk("lit_hst_be", 32'(l_be), 32'hC);
    chk("lit_hst_wd", l_wd, 32'hABCD_ABCD);
    chk("lit_hst_we", 32'(l_we), 32'h1);
    chk("lit_hst_rdata", l_rdata, 32'h0);
    op(32'h101, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 0, 1'b0);
    chk("lit_mis_err", 32'(l_err), 32'h1);
    op(32'h5, 1'b1, 2'd0, 1'b0, 32'h1234_5677, 32'h0, 2, 1'b0);
    chk("lit_bst_be", 32'(l_be), 32'h2);
    chk("lit_bst_wd", l_wd, 32'h7777_7777);
    op(32'h42, 1'b0, 2'd1, 1'b0, 32'h0, 32'h8001_1234, 1, 1'b0);
    chk("lit_shalf", l_rdata, 32'hFFFF_8001);
    op(32'h40, 1'b0, 2'd1, 1'b1, 32'h0, 32'h1234_F00F, 0, 1'b0);
    chk("lit_uhalf", l_rdata, 32'h0000_F00F);
    op(32'h3C, 1'b1, 2'd2, 1'b0, 32'hCAFE_F00D, 32'h0, 1, 1'b0);
    op(32'h101, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0000_7F00, 3, 1'b0);
    chk("lit_pos_byte", l_rdata, 32'h0000_007F);
    op(32'h41, 1'b0, 2'd1, 1'b0, 32'h0, 32'h0, 0, 1'b0);
    op(32'h80, 1'b0, 2'd3, 1'b0, 32'h0, 32'h0, 0, 1'b0);
    op(32'h102, 1'b1, 2'd2, 1'b0, 32'h1111_2222, 32'h0, 0, 1'b0);
    reset_in_wait();
    op(32'h300, 1'b0, 2'd2, 1'b0, 32'h0, 32'hA5A5_0F0F, 0, 1'b0);
    chk("lit_after_rst", l_rdata, 32'hA5A5_0F0F);
`ifdef TCM_LSU_TIMEOUT_EN
    op(32'h1000_0000, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 0, 1'b1);
    chk("lit_timeout_err", 32'(l_err), 32'h1);
    @(negedge aclk);
    chk("timeout_ready", 32'(req_ready), 32'h1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tcm_lsu.md
# tcm_lsu

Load/store initiator for the data port (port B) of the dual-port tightly-coupled memory. It accepts one core memory operation at a time: byte, half-word or word, read or write. It drives the TCM request/grant/valid handshake with the correct byte enables and lane-replicated write data. It returns aligned, sign- or zero-extended load data, or an error, to the core pipeline.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16, cycles `request_b` may stay high without `grant_b` before the access faults (used only with `TCM_LSU_TIMEOUT_EN`).

Ports:
- aclk  in  1  clock; all logic on rising edge.
- areset  in  1  reset. One clock; reset is synchronous and active-high.
- req_valid  in  1  core presents an operation.
- req_ready  out  1  block can accept; high only in IDLE.
- req_addr  in  32  byte address.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved.
- req_unsigned  in  1  loads: zero-extend when 1, sign-extend when 0.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  one-cycle pulse; response complete.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  valid with `rsp_valid`; misaligned, reserved size or timeout.
- address_b  out  32  word-aligned TCM address (bits [1:0] = 0).
- request_b  out  1  TCM request.
- write_enable_b  out  1  TCM write.
- write_byte_enable_b  out  4  TCM lane enables.
- write_data_b  out  32  lane-replicated store data.
- read_data_b  in  32  TCM read data, valid when `valid_b` is high.
- grant_b  in  1  combinational grant, same cycle as `request_b`.
- valid_b  in  1  access complete, one cycle after grant.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: `req_ready` = 1. On `req_valid`, register the address, we, size, unsigned flag, enables and data.
  - Misaligned or reserved size goes to RESP with err = 1 and issues no TCM request.
  - Otherwise go to REQ.
- Misaligned means: half with addr[0] = 1; word with addr[1:0] ≠ 0; size = 3.
- REQ: `request_b` = 1. All port-B outputs come from registers and stay stable until grant. `grant_b` = 1 moves to WAIT. `request_b` drops the next cycle.
- WAIT: `request_b` = 0. `valid_b` = 1 captures read data (loads) and moves to RESP.
- RESP: `rsp_valid` = 1 for exactly one cycle, then IDLE. The core must accept the response; there is no backpressure.
- `valid_b` seen outside WAIT is ignored.
- Byte enables and write data:
  - Byte: be = 4'b0001 << addr[1:0]; data = {4{wdata[7:0]}}.
  - Half: be = 4'b0011 << addr[1:0]; data = {2{wdata[15:0]}}.
  - Word: be = 4'hF; data = wdata.
  - Loads: `write_enable_b` = 0, be = 0.
- Load extraction:
  - Byte: lane = read_data_b >> (8·addr[1:0]).
  - Half: lane = read_data_b >> (16·addr[1]).
  - Lane is sign- or zero-extended to 32 bits per `req_unsigned`.
  - Word is passed through unchanged.

## Timing
- Reset values:
  - `req_ready` = 0 during reset, 1 the first cycle after.
  - `request_b`, `write_enable_b`, `rsp_valid`, `rsp_err` = 0.
  - `write_byte_enable_b` = 0.
  - `address_b`, `write_data_b`, `rsp_rdata` = 0.
  - State = IDLE.
- Best-case latency:
  - Accept at cycle 0.
  - `request_b` + `grant_b` at cycle 1.
  - `valid_b` at cycle 2.
  - `rsp_valid` at cycle 3.
  - Next accept at cycle 4.
- Grant delayed N cycles adds N cycles of latency.
- Error for misaligned/reserved: `rsp_valid` at cycle 1; `request_b` never asserted.
- Reset during REQ or WAIT: returns to IDLE the next cycle, drops `request_b`, and produces no response. A late `valid_b` is ignored.

## Configuration
- `TCM_LSU_TIMEOUT_EN` defined:
  - A counter clears on entry to REQ and increments each REQ cycle without grant.
  - When it reaches TIMEOUT_CYCLES, the FSM goes to RESP with err = 1 and drops `request_b`. This covers out-of-range addresses, which the TCM never grants.
- Undefined: no counter; REQ waits indefinitely for `grant_b`.

## Test plan
- Word load, addr 0x100, TCM returns 0xDEADBEEF with immediate grant → `rsp_valid` at cycle 3, rdata 0xDEADBEEF, err 0.
- Signed byte load, addr 0x103, read_data_b 0x80112233 → be 0, rdata 0xFFFFFF80. Same with unsigned → 0x00000080.
- Half store, addr 0x22, wdata 0x0000ABCD → address_b 0x20, be 4'b1100, write_data_b 0xABCDABCD, write_enable_b 1, rsp_rdata 0.
- Word load, addr 0x101 → no `request_b`; `rsp_valid` + `rsp_err` at cycle 1.
- With `TCM_LSU_TIMEOUT_EN` and TIMEOUT_CYCLES = 16, `grant_b` held 0 → `request_b` high for 16 cycles, then `rsp_err` pulse and `req_ready` back to 1.
- `areset` asserted in WAIT, then `valid_b` pulses → no `rsp_valid`; all outputs at reset values; next word load completes normally.
